// File: rtl/i2c_txbuf_scheduler_if.sv
// Handshake bundle between the host writer, the ping-pong TX buffer scheduler
// and the I2C TX controller.
interface i2c_txbuf_scheduler_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 6
);
   logic              host_start;
   logic [CNT_W-1:0]  burst_len;
   logic              host_wr_valid;
   logic              host_wr_ready;
   logic [DATA_W-1:0] host_wr_data;
   logic              start_tx;
   logic              byte_valid;
   logic [DATA_W-1:0] byte_data;
   logic              byte_take;
   logic              byte_ack;
   logic              byte_nack;
   logic              send_stop;
   logic              stop_done;
   logic              busy;
   logic              burst_done;
   logic              abort;
   logic              buf_sel;

   modport master (
      output host_start, burst_len, host_wr_valid, host_wr_data,
      output byte_take, byte_ack, byte_nack, stop_done,
      input  host_wr_ready, start_tx, byte_valid, byte_data,
      input  send_stop, busy, burst_done, abort, buf_sel
   );

   modport slave (
      input  host_start, burst_len, host_wr_valid, host_wr_data,
      input  byte_take, byte_ack, byte_nack, stop_done,
      output host_wr_ready, start_tx, byte_valid, byte_data,
      output send_stop, busy, burst_done, abort, buf_sel
   );
endinterface

// File: rtl/i2c_txbuf_scheduler.sv
// Ping-pong TX buffer scheduler: owns two byte buffers, feeds the I2C controller
// alternately from them, counts the burst and sequences START/STOP requests.
module i2c_txbuf_scheduler #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 6
) (
   input logic                  clk,
   input logic                  rst,
   i2c_txbuf_scheduler_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2,
      STOP = 2'd3
   } state_t;

   state_t            state_r, state_s;
   logic [DATA_W-1:0] buf_r [2];
   logic [1:0]        full_r, full_s;
   logic              wr_ptr_r, wr_ptr_s;
   logic              rd_ptr_r, rd_ptr_s;
   logic [CNT_W-1:0]  in_cnt_r, in_cnt_s;
   logic [CNT_W-1:0]  out_cnt_r, out_cnt_s;
   logic [CNT_W-1:0]  ack_cnt_r, ack_cnt_s;
   logic [CNT_W-1:0]  len_r, len_s;
   logic [CNT_W-1:0]  ack_inc_s;
   logic              abort_flag_r, abort_flag_s;
   logic              start_tx_r, start_tx_s;
   logic              burst_done_r, burst_done_s;
   logic              abort_r, abort_s;
   logic              wr_ready_s, wr_en_s, take_en_s;

   // Handshake qualifiers; ready is built from registered flags only, so byte_take never reaches it.
   always_comb begin
      wr_ready_s = ((state_r == FILL) || (state_r == RUN)) && !full_r[wr_ptr_r] && (in_cnt_r < len_r);
      wr_en_s    = bus.host_wr_valid && wr_ready_s;
      take_en_s  = (state_r == RUN) && bus.byte_take && full_r[rd_ptr_r];
      ack_inc_s  = ack_cnt_r + CNT_W'(1);
   end

   // Next-state, buffer ownership bookkeeping and pulse generation.
   always_comb begin
      state_s      = state_r;
      full_s       = full_r;
      wr_ptr_s     = wr_ptr_r;
      rd_ptr_s     = rd_ptr_r;
      in_cnt_s     = in_cnt_r;
      out_cnt_s    = out_cnt_r;
      ack_cnt_s    = ack_cnt_r;
      len_s        = len_r;
      abort_flag_s = abort_flag_r;
      start_tx_s   = 1'b0;
      burst_done_s = 1'b0;
      abort_s      = 1'b0;

      if (wr_en_s) begin
         full_s[wr_ptr_r] = 1'b1;
         wr_ptr_s         = ~wr_ptr_r;
         in_cnt_s         = in_cnt_r + CNT_W'(1);
      end else begin
         wr_ptr_s = wr_ptr_r;
      end

      if (take_en_s) begin
         full_s[rd_ptr_r] = 1'b0;
         rd_ptr_s         = ~rd_ptr_r;
         out_cnt_s        = out_cnt_r + CNT_W'(1);
      end else begin
         rd_ptr_s = rd_ptr_r;
      end

      case (state_r)
         IDLE: begin
            // Pointers restart at buffer 0 so a burst cut short by NACK cannot leave them skewed.
            if (bus.host_start && (bus.burst_len != {CNT_W{1'b0}})) begin
               state_s      = FILL;
               len_s        = bus.burst_len;
               in_cnt_s     = {CNT_W{1'b0}};
               out_cnt_s    = {CNT_W{1'b0}};
               ack_cnt_s    = {CNT_W{1'b0}};
               wr_ptr_s     = 1'b0;
               rd_ptr_s     = 1'b0;
               full_s       = 2'b00;
               abort_flag_s = 1'b0;
            end else begin
               state_s = IDLE;
            end
         end
         FILL: begin
            if (wr_en_s) begin
               state_s    = RUN;
               start_tx_s = 1'b1;
            end else begin
               state_s = FILL;
            end
         end
         RUN: begin
            if (bus.byte_nack) begin
               full_s       = 2'b00;
               abort_flag_s = 1'b1;
               state_s      = STOP;
            end else if (bus.byte_ack) begin
               ack_cnt_s = ack_inc_s;
               if (ack_inc_s == len_r) begin
                  state_s = STOP;
               end else begin
                  state_s = RUN;
               end
            end else begin
               state_s = RUN;
            end
         end
         STOP: begin
            if (bus.stop_done) begin
               if (abort_flag_r) begin
                  abort_s = 1'b1;
               end else begin
                  burst_done_s = 1'b1;
               end
               abort_flag_s = 1'b0;
               state_s      = IDLE;
            end else begin
               state_s = STOP;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Control state and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         full_r       <= 2'b00;
         wr_ptr_r     <= 1'b0;
         rd_ptr_r     <= 1'b0;
         in_cnt_r     <= {CNT_W{1'b0}};
         out_cnt_r    <= {CNT_W{1'b0}};
         ack_cnt_r    <= {CNT_W{1'b0}};
         len_r        <= {CNT_W{1'b0}};
         abort_flag_r <= 1'b0;
         start_tx_r   <= 1'b0;
         burst_done_r <= 1'b0;
         abort_r      <= 1'b0;
      end else begin
         state_r      <= state_s;
         full_r       <= full_s;
         wr_ptr_r     <= wr_ptr_s;
         rd_ptr_r     <= rd_ptr_s;
         in_cnt_r     <= in_cnt_s;
         out_cnt_r    <= out_cnt_s;
         ack_cnt_r    <= ack_cnt_s;
         len_r        <= len_s;
         abort_flag_r <= abort_flag_s;
         start_tx_r   <= start_tx_s;
         burst_done_r <= burst_done_s;
         abort_r      <= abort_s;
      end
   end

   // Byte storage; cleared on reset so byte_data reads zero afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_r[0] <= {DATA_W{1'b0}};
         buf_r[1] <= {DATA_W{1'b0}};
      end else if (wr_en_s) begin
         buf_r[wr_ptr_r] <= bus.host_wr_data;
      end else begin
         buf_r[wr_ptr_r] <= buf_r[wr_ptr_r];
      end
   end

   assign bus.host_wr_ready = wr_ready_s;
   assign bus.byte_valid    = full_r[rd_ptr_r];
   assign bus.byte_data     = buf_r[rd_ptr_r];
   assign bus.start_tx      = start_tx_r;
   assign bus.send_stop     = (state_r == STOP);
   assign bus.busy          = (state_r != IDLE);
   assign bus.burst_done    = burst_done_r;
   assign bus.abort         = abort_r;
   assign bus.buf_sel       = rd_ptr_r;
endmodule

// File: tb/tb_i2c_txbuf_scheduler.sv
// Randomized bench for i2c_txbuf_scheduler against a queue-based transaction model
// of the two-deep TX buffer, burst counting and START/STOP sequencing.
module tb_i2c_txbuf_scheduler;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   i2c_txbuf_scheduler_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
   i2c_txbuf_scheduler #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int err_cnt = 0;
   int chk_cnt = 0;

   // reference model: pending bytes in order, plus burst progress counts
   bit         m_busy, m_stop, m_started, m_abt;
   int         m_len, m_wr, m_tk, m_ack;
   logic [7:0] q[$];
   bit         e_start, e_done, e_abort;

   // stimulus knobs and agents
   int         k_take_dly, k_ack_dly, k_nack_at, k_gap_pct;
   bit         k_take_always;
   logic [7:0] hbytes[$];
   int         hidx, hold_left, vwait, stop_wait, acks_sent;
   int         ackq[$];
   logic [7:0] taken_d[$];
   bit         taken_s[$];
   int         n_start, n_done, n_abort;
   logic [7:0] pat [3] = '{8'hA5, 8'h3C, 8'hF0};

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      chk_cnt++;
      if (obs !== expv) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   task automatic model_edge(output bit wr_ok, output bit take_ok);
      bit ready, run;
      wr_ok = 1'b0; take_ok = 1'b0;
      e_start = 1'b0; e_done = 1'b0; e_abort = 1'b0;
      if (rst) begin
         m_busy = 1'b0; m_stop = 1'b0; m_started = 1'b0; m_abt = 1'b0;
         m_len = 0; m_wr = 0; m_tk = 0; m_ack = 0;
         q.delete();
      end else if (!m_busy) begin
         if (bus.host_start && bus.burst_len != 0) begin
            m_busy = 1'b1; m_started = 1'b0; m_abt = 1'b0;
            m_len = int'(bus.burst_len); m_wr = 0; m_tk = 0; m_ack = 0;
            q.delete();
         end
      end else if (m_stop) begin
         if (bus.stop_done) begin
            if (m_abt) e_abort = 1'b1;
            else e_done = 1'b1;
            m_busy = 1'b0; m_stop = 1'b0; m_abt = 1'b0;
         end
      end else begin
         ready   = (q.size() < 2) && (m_wr < m_len);
         run     = m_started;
         take_ok = run && bus.byte_take && (q.size() > 0);
         wr_ok   = bus.host_wr_valid && ready;
         if (take_ok) begin
            void'(q.pop_front());
            m_tk++;
         end
         if (wr_ok) begin
            q.push_back(bus.host_wr_data);
            m_wr++;
            if (!m_started) begin
               m_started = 1'b1;
               e_start   = 1'b1;
            end
         end
         if (run && bus.byte_nack) begin
            q.delete();
            m_abt  = 1'b1;
            m_stop = 1'b1;
         end else if (run && bus.byte_ack) begin
            m_ack++;
            if (m_ack == m_len) m_stop = 1'b1;
         end
      end
   endtask

   task automatic check_outputs();
      check_eq("host_wr_ready", bus.host_wr_ready, m_busy && !m_stop && (q.size() < 2) && (m_wr < m_len));
      check_eq("byte_valid", bus.byte_valid, q.size() > 0);
      if (q.size() > 0) check_eq("byte_data", bus.byte_data, q[0]);
      check_eq("buf_sel", bus.buf_sel, m_tk % 2);
      check_eq("start_tx", bus.start_tx, e_start);
      check_eq("send_stop", bus.send_stop, m_stop);
      check_eq("busy", bus.busy, m_busy);
      check_eq("burst_done", bus.burst_done, e_done);
      check_eq("abort", bus.abort, e_abort);
   endtask

   task automatic drive_inputs();
      bus.host_start    = 1'b0;
      bus.burst_len     = CNT_W'($urandom_range(1, 63));
      bus.host_wr_valid = 1'b0;
      bus.host_wr_data  = 8'($urandom);
      bus.byte_take     = 1'b0;
      bus.byte_ack      = 1'b0;
      bus.byte_nack     = 1'b0;
      bus.stop_done     = 1'b0;
      if (!m_busy) begin
         bus.host_wr_valid = 1'($urandom_range(1));
      end else if (m_stop) begin
         bus.host_start    = 1'($urandom_range(1));
         bus.host_wr_valid = 1'($urandom_range(1));
         if (stop_wait > 0) stop_wait--;
         else bus.stop_done = 1'b1;
      end else begin
         if (hidx == 1 && hold_left > 0) begin
            hold_left--;
         end else if (hidx < hbytes.size() && $urandom_range(99) >= k_gap_pct) begin
            bus.host_wr_valid = 1'b1;
            bus.host_wr_data  = hbytes[hidx];
         end
         if (k_take_always) begin
            bus.byte_take = 1'b1;
         end else if (q.size() > 0 && ackq.size() == 0) begin
            if (vwait >= k_take_dly) bus.byte_take = 1'b1;
            else vwait++;
         end
         if (ackq.size() > 0 && ackq[0] == 0) begin
            acks_sent++;
            bus.byte_ack = 1'b1;
            if (acks_sent == k_nack_at) bus.byte_nack = 1'b1;
            void'(ackq.pop_front());
         end
         foreach (ackq[i]) if (ackq[i] > 0) ackq[i]--;
      end
   endtask

   task automatic cycle();
      bit wr_ok, take_ok;
      model_edge(wr_ok, take_ok);
      if (wr_ok) hidx++;
      if (take_ok) begin
         taken_d.push_back(bus.byte_data);
         taken_s.push_back(bus.buf_sel);
         ackq.push_back(k_ack_dly);
         vwait = 0;
      end
      @(posedge clk);
      #1;
      if (bus.start_tx) n_start++;
      if (bus.burst_done) n_done++;
      if (bus.abort) n_abort++;
      check_outputs();
      drive_inputs();
   endtask

   // mode 0: run to completion; mode 1: reset once a byte is taken and one buffer is full
   task automatic run_burst(input int len, input int take_dly, input int ack_dly, input int nack_at,
                            input int gap_pct, input bit take_always, input int hold_cyc,
                            input bit fixed, input int mode);
      int cnt;
      bit did_rst;
      hbytes.delete(); taken_d.delete(); taken_s.delete(); ackq.delete();
      for (int i = 0; i < len; i++) hbytes.push_back(fixed ? pat[i % 3] : 8'($urandom));
      k_take_dly = take_dly; k_ack_dly = ack_dly; k_nack_at = nack_at;
      k_gap_pct = gap_pct; k_take_always = take_always;
      hidx = 0; hold_left = hold_cyc; vwait = 0; acks_sent = 0;
      stop_wait = $urandom_range(4);
      n_start = 0; n_done = 0; n_abort = 0;
      did_rst = 1'b0;
      bus.host_start = 1'b1;
      bus.burst_len  = CNT_W'(len);
      cycle();
      check_eq("burst_accepted", bus.busy, 1'b1);
      cnt = 0;
      while (m_busy && cnt < 3000) begin
         if (mode == 1 && m_tk == 1 && q.size() == 1) begin
            rst = 1'b1;
            cycle();
            rst = 1'b0;
            did_rst = 1'b1;
            check_eq("rst_busy", bus.busy, 1'b0);
            check_eq("rst_byte_valid", bus.byte_valid, 1'b0);
            check_eq("rst_send_stop", bus.send_stop, 1'b0);
            check_eq("rst_buf_sel", bus.buf_sel, 1'b0);
            check_eq("rst_byte_data", bus.byte_data, 8'h00);
         end else begin
            cycle();
         end
         cnt++;
      end
      check_eq("burst_timeout", cnt < 3000, 1'b1);
      check_eq("start_tx_pulses", n_start, 1);
      check_eq("burst_done_pulses", n_done, (nack_at > 0 || mode == 1) ? 0 : 1);
      check_eq("abort_pulses", n_abort, (nack_at > 0 && mode == 0) ? 1 : 0);
      if (mode == 1) check_eq("rst_applied", did_rst, 1'b1);
      if (nack_at == 0 && mode == 0) check_eq("take_count", taken_d.size(), len);
      for (int i = 0; i < taken_d.size(); i++) begin
         check_eq("take_order", taken_d[i], hbytes[i]);
         check_eq("take_buf_sel", taken_s[i], i % 2);
      end
   endtask

   initial begin
      drive_inputs();
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      check_eq("reset_busy", bus.busy, 1'b0);
      check_eq("reset_ready", bus.host_wr_ready, 1'b0);
      check_eq("reset_byte_valid", bus.byte_valid, 1'b0);
      check_eq("reset_byte_data", bus.byte_data, 8'h00);
      check_eq("reset_send_stop", bus.send_stop, 1'b0);
      check_eq("reset_buf_sel", bus.buf_sel, 1'b0);

      // three fixed bytes, take two cycles after valid, ack nine later
      run_burst(3, 2, 9, 0, 0, 1'b0, 0, 1'b1, 0);
      // ping-pong saturation
      run_burst(8, 3, 4, 0, 0, 1'b0, 0, 1'b0, 0);
      // underrun: second byte held back while the controller keeps taking
      run_burst(2, 0, 5, 0, 0, 1'b1, 20, 1'b0, 0);
      // NACK together with ACK on the second byte
      run_burst(4, 1, 3, 2, 0, 1'b0, 0, 1'b0, 0);
      // zero-length start is ignored
      n_start = 0;
      for (int i = 0; i < 3; i++) begin
         bus.host_start = 1'b1;
         bus.burst_len  = {CNT_W{1'b0}};
         cycle();
         check_eq("zero_len_busy", bus.busy, 1'b0);
      end
      check_eq("zero_len_start_tx", n_start, 0);
      // reset mid-run, then a one-byte burst
      run_burst(4, 0, 6, 0, 0, 1'b0, 0, 1'b0, 1);
      run_burst(1, 1, 3, 0, 0, 1'b0, 0, 1'b0, 0);
      // longest burst
      run_burst(63, 0, 1, 0, 0, 1'b0, 0, 1'b0, 0);
      // random bursts
      for (int b = 0; b < 12; b++) begin
         int len, nack;
         len  = $urandom_range(1, 24);
         nack = ($urandom_range(3) == 0) ? $urandom_range(1, len) : 0;
         run_burst(len, $urandom_range(3), $urandom_range(1, 10), nack, $urandom_range(60),
                   1'($urandom_range(4) == 0), 0, 1'b0, 0);
      end
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/i2c_txbuf_scheduler.md
Name: i2c_txbuf_scheduler

Overview:
Ping-pong scheduler for the double-buffered I2C transmit path. It owns the two TX byte buffers and accepts bytes from the host side. It hands bytes alternately to the TX controller's shift stage and counts the burst. It also issues the start and stop requests to the controller, so the controller never sees buffer-ownership decisions.

Parameters:
DATA_W, 8, byte width of each TX buffer
CNT_W, 6, width of burst length and burst counters (max burst 2^CNT_W-1 = 63)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
host_start  input  1  begin a burst; sampled only in IDLE
burst_len  input  CNT_W  bytes in burst; latched when host_start is accepted
host_wr_valid  input  1  host byte valid
host_wr_ready  output  1  scheduler can accept host byte this cycle
host_wr_data  input  DATA_W  host byte
start_tx  output  1  one-cycle pulse to TX controller: send START plus address
byte_valid  output  1  buffer at rd_ptr holds a byte for the controller
byte_data  output  DATA_W  contents of buffer at rd_ptr
byte_take  input  1  controller loads byte_data into its shift register
byte_ack  input  1  one-cycle pulse: byte sent and slave ACK received
byte_nack  input  1  one-cycle pulse: slave NACK on current byte
send_stop  output  1  level: request STOP; held until stop_done
stop_done  input  1  one-cycle pulse: STOP condition completed
busy  output  1  state != IDLE
burst_done  output  1  one-cycle pulse: all burst_len bytes ACKed and STOP done
abort  output  1  one-cycle pulse: burst terminated by NACK
buf_sel  output  1  current rd_ptr, for debug and waveform

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE; wr_ptr=rd_ptr=0; full[1:0]=0; in_cnt=out_cnt=ack_cnt=0; len_q=0.
  - Outputs 0: host_wr_ready, start_tx, byte_valid, send_stop, busy, burst_done, abort, buf_sel.
  - byte_data=0 after reset (buffers cleared).
  - Reset mid-burst discards both buffers, and send_stop drops the next cycle.
- States: IDLE, FILL, RUN, STOP.
- IDLE:
  - host_start=1 with burst_len!=0: latch len_q, clear counters, go FILL.
  - host_start with burst_len==0: ignored, no pulses, stays IDLE.
- Host write:
  - host_wr_ready = (state==FILL or RUN) and !full[wr_ptr] and in_cnt<len_q.
  - On valid&ready: buffer[wr_ptr]<=data, full[wr_ptr]<=1, wr_ptr toggles, in_cnt+1.
  - The ready term uses registered flags; no combinational path from byte_take.
- FILL: on the first accepted write, go RUN and pulse start_tx in the following cycle (same cycle RUN is entered).
- RUN, controller side:
  - byte_valid = full[rd_ptr]; byte_data = buffer[rd_ptr] (combinational mux, rd_ptr registered).
  - byte_take while byte_valid: full[rd_ptr]<=0, rd_ptr toggles, out_cnt+1.
  - byte_take while !byte_valid (underrun) is ignored; the controller must hold SCL and retry.
  - A host write into buffer X and a take from buffer Y in the same cycle are both performed.
  - Write and take can never target the same buffer in one cycle, because full gates both.
- byte_ack: ack_cnt+1. When ack_cnt reaches len_q (same-cycle compare on the incremented value), go STOP.
- byte_nack in RUN: clear full[1:0], set abort_flag, go STOP. This takes priority over a simultaneous byte_ack.
- STOP:
  - send_stop=1 and host_wr_ready=0.
  - On stop_done: pulse burst_done (or abort if abort_flag), clear abort_flag, go IDLE.
  - host_start during STOP is ignored.
- Counters are CNT_W bits and never wrap, since they are bounded by len_q.
- host_wr_valid outside FILL/RUN: no effect.
- Latency:
  - host write to byte_valid: 1 cycle.
  - byte_take to next byte_valid: 1 cycle if the other buffer is already full.

Test Plan:
- rst, host_start with burst_len=3, write A5,3C,F0 back-to-back; controller takes each 2 cycles after valid and acks 9 cycles later -> start_tx one pulse; byte_data sequence A5,3C,F0 with buf_sel 0,1,0; host_wr_ready low when both full; send_stop after 3rd ack; burst_done 1 cycle after stop_done.
- Ping-pong saturation, burst_len=8, host always valid -> host_wr_ready deasserts whenever full=2'b11; no byte lost or duplicated; 8 takes and 8 acks; busy drops after burst_done.
- Underrun, burst_len=2, second host byte delayed 20 cycles with controller asserting byte_take continuously -> only 2 takes counted; out_cnt=2; byte order preserved.
- NACK on byte 2 of burst_len=4, pulsed with a simultaneous byte_ack -> full=0; send_stop asserted; abort pulses after stop_done; burst_done stays 0; busy=0 and next host_start accepted.
- host_start with burst_len=0 -> remains IDLE; busy, start_tx and host_wr_ready stay 0.
- rst asserted in RUN with one buffer full -> next cycle state IDLE, byte_valid=0, send_stop=0, buf_sel=0; a new burst_len=1 burst completes normally.
